// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction/immediate byte fetch stage with PC ownership
//
// Owns the program counter and performs single-byte bus reads at PC on
// behalf of the decoder. Opcode fetches and little-endian immediate byte
// pairs are assembled here; control-flow updates from the decoder are
// applied only while idle so that a fetch never races a PC rewrite.
//
// Ports:
//   clk, nrst                    clock, asynchronous active-low reset
//   next_instr_req, imm_byte_req decoder fetch requests (opcode wins)
//   hold, clear                  stall new requests / abort all activity
//   pc_load, call_or_jump,
//   cond_true, jump_is_relative,
//   pc_offset, jump_target       control-flow update request
//   opcode, imm_i                fetched opcode / assembled immediate
//   memory_acknowledge           one-cycle pulse per delivered byte
//   pc, fetch_error              program counter, sticky timeout flag
//   bus_rd_req, bus_addr,
//   bus_rdata, bus_ack           single-byte read bus
module fetch_unit #(
    parameter logic [15:0] RESET_PC           = 16'h0000,
    parameter logic [7:0]  BUS_TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        next_instr_req,
    input  logic        imm_byte_req,
    input  logic        hold,
    input  logic        clear,
    input  logic        pc_load,
    input  logic        call_or_jump,
    input  logic        cond_true,
    input  logic        jump_is_relative,
    input  logic [7:0]  pc_offset,
    input  logic [15:0] jump_target,
    output logic [7:0]  opcode,
    output logic [15:0] imm_i,
    output logic        memory_acknowledge,
    output logic [15:0] pc,
    output logic        fetch_error,
    output logic        bus_rd_req,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OP_REQ  = 2'd1,
        IMM_REQ = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [7:0]  opcode_q;
    logic [15:0] imm_q;
    logic        ack_q;
    logic        rd_req_q;
    logic [15:0] addr_q;
    logic        err_q;
    logic        byte_cnt_q;
    logic [7:0]  tmo_q;
    logic        pend_op_q;
    logic        pend_imm_q;

    // Jump captured while busy, replayed on the first idle cycle.
    logic        pend_jmp_q;
    logic        pj_cj_q;
    logic        pj_ct_q;
    logic        pj_rel_q;
    logic [7:0]  pj_off_q;
    logic [15:0] pj_tgt_q;

    // PC as seen by an idle-cycle fetch: a same-cycle pc_load takes
    // precedence over an older pending jump, and either is committed
    // before the bus address is chosen.
    logic        j_cj, j_ct, j_rel, j_valid;
    logic [7:0]  j_off;
    logic [15:0] j_tgt;
    logic [15:0] pc_d;

    always_comb begin
        j_valid = pc_load | pend_jmp_q;
        j_cj    = pc_load ? call_or_jump     : pj_cj_q;
        j_ct    = pc_load ? cond_true        : pj_ct_q;
        j_rel   = pc_load ? jump_is_relative : pj_rel_q;
        j_off   = pc_load ? pc_offset        : pj_off_q;
        j_tgt   = pc_load ? jump_target      : pj_tgt_q;
        pc_d    = pc_q;
        if (j_valid && j_cj && j_ct) begin
            pc_d = j_rel ? (pc_q + {{8{j_off[7]}}, j_off}) : j_tgt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            opcode_q   <= 8'h00;
            imm_q      <= 16'h0000;
            ack_q      <= 1'b0;
            rd_req_q   <= 1'b0;
            addr_q     <= 16'h0000;
            err_q      <= 1'b0;
            byte_cnt_q <= 1'b0;
            tmo_q      <= 8'h00;
            pend_op_q  <= 1'b0;
            pend_imm_q <= 1'b0;
            pend_jmp_q <= 1'b0;
            pj_cj_q    <= 1'b0;
            pj_ct_q    <= 1'b0;
            pj_rel_q   <= 1'b0;
            pj_off_q   <= 8'h00;
            pj_tgt_q   <= 16'h0000;
        end else begin
            ack_q <= 1'b0;
            if (clear) begin
                state_q    <= IDLE;
                rd_req_q   <= 1'b0;
                err_q      <= 1'b0;
                byte_cnt_q <= 1'b0;
                tmo_q      <= 8'h00;
                pend_op_q  <= 1'b0;
                pend_imm_q <= 1'b0;
                pend_jmp_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        pc_q       <= pc_d;
                        pend_jmp_q <= 1'b0;
                        tmo_q      <= 8'h00;
                        if (hold) begin
                            if (next_instr_req) begin
                                pend_op_q  <= 1'b1;
                                pend_imm_q <= 1'b0;
                            end else if (imm_byte_req && !pend_op_q) begin
                                pend_imm_q <= 1'b1;
                            end
                        end else if (next_instr_req || pend_op_q) begin
                            state_q    <= OP_REQ;
                            rd_req_q   <= 1'b1;
                            addr_q     <= pc_d;
                            pend_op_q  <= 1'b0;
                            pend_imm_q <= 1'b0;
                        end else if (imm_byte_req || pend_imm_q) begin
                            state_q    <= IMM_REQ;
                            rd_req_q   <= 1'b1;
                            addr_q     <= pc_d;
                            pend_imm_q <= 1'b0;
                        end
                    end
                    default: begin
                        if (pc_load) begin
                            pend_jmp_q <= 1'b1;
                            pj_cj_q    <= call_or_jump;
                            pj_ct_q    <= cond_true;
                            pj_rel_q   <= jump_is_relative;
                            pj_off_q   <= pc_offset;
                            pj_tgt_q   <= jump_target;
                        end
                        if (bus_ack) begin
                            state_q  <= IDLE;
                            rd_req_q <= 1'b0;
                            pc_q     <= pc_q + 16'd1;
                            ack_q    <= 1'b1;
                            if (state_q == OP_REQ) begin
                                opcode_q   <= bus_rdata;
                                imm_q      <= 16'h0000;
                                byte_cnt_q <= 1'b0;
                            end else if (!byte_cnt_q) begin
                                imm_q      <= {8'h00, bus_rdata};
                                byte_cnt_q <= 1'b1;
                            end else begin
                                imm_q[15:8] <= bus_rdata;
                                byte_cnt_q  <= 1'b0;
                            end
                        end else if (BUS_TIMEOUT_CYCLES != 8'd0 &&
                                     tmo_q == BUS_TIMEOUT_CYCLES - 8'd1) begin
                            state_q  <= IDLE;
                            rd_req_q <= 1'b0;
                            err_q    <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign opcode             = opcode_q;
    assign imm_i              = imm_q;
    assign memory_acknowledge = ack_q;
    assign pc                 = pc_q;
    assign fetch_error        = err_q;
    assign bus_rd_req         = rd_req_q;
    assign bus_addr           = addr_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction/immediate byte fetch stage that sits directly upstream of instruction_decoder. It owns the program counter and issues single-byte reads on the memory bus at PC. It presents opcode, assembled imm_i and a one-cycle memory_acknowledge pulse to the decoder, and applies jump/call PC updates requested by the decoder.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
BUS_TIMEOUT_CYCLES, 8'd255, cycles to wait for bus_ack before aborting; 0 disables timeout.

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
next_instr_req  in  1  decoder requests opcode fetch at PC
imm_byte_req  in  1  decoder requests next immediate byte at PC
hold  in  1  stall: no new bus request is started
clear  in  1  synchronous abort of fetch activity
pc_load  in  1  strobe: apply control-flow update
call_or_jump  in  1  update is a jump/call
cond_true  in  1  branch condition result
jump_is_relative  in  1  1: PC += sext(pc_offset); 0: PC = jump_target
pc_offset  in  8  signed relative offset
jump_target  in  16  absolute target
opcode  out  8  last fetched opcode
imm_i  out  16  assembled immediate
memory_acknowledge  out  1  one-cycle pulse: opcode/imm byte valid
pc  out  16  current program counter
fetch_error  out  1  sticky bus timeout flag
bus_rd_req  out  1  bus read request (level)
bus_addr  out  16  bus read address
bus_rdata  in  8  bus read data
bus_ack  in  1  bus read complete, bus_rdata valid

Behaviour:
- Reset (nrst low, async): state IDLE; pc=RESET_PC; opcode=8'h00; imm_i=0; memory_acknowledge=0; bus_rd_req=0; bus_addr=0; fetch_error=0; byte counter=0; pending request/jump cleared.
- States: IDLE, OP_REQ, IMM_REQ. All outputs registered.
- IDLE, hold=0, next_instr_req=1 -> OP_REQ next cycle; bus_rd_req=1, bus_addr=pc. next_instr_req has priority over imm_byte_req; the losing request is dropped.
- IDLE, hold=0, imm_byte_req=1 -> IMM_REQ, bus_rd_req=1, bus_addr=pc.
- Request while hold=1 in IDLE: latched (one pending slot, opcode has priority), issued the first cycle hold=0. Requests arriving in OP_REQ/IMM_REQ are ignored. hold does not abort an in-flight request.
- OP_REQ/IMM_REQ: bus_rd_req and bus_addr stay stable until the bus_ack cycle. On bus_ack: bus_rd_req=0 next cycle; pc=pc+1 (mod 2^16); memory_acknowledge=1 for exactly one cycle; return to IDLE.
  - OP_REQ ack: opcode=bus_rdata, imm_i=0, byte counter=0.
  - IMM_REQ ack, counter 0: imm_i={8'h00,bus_rdata}, counter=1.
  - IMM_REQ ack, counter 1: imm_i[15:8]=bus_rdata, counter=0 (little-endian). A third byte restarts the pair.
- Minimum latency request->memory_acknowledge: 2 cycles with ack in first bus cycle.
- pc_load is accepted in IDLE only. If it arrives while busy, it is held pending and applied on return to IDLE, before any new fetch.
  - Applied with call_or_jump=1 and cond_true=1: pc = jump_is_relative ? pc+sext(pc_offset) : jump_target, wrap mod 2^16.
  - Otherwise pc is unchanged.
  - pc_load together with a fetch request in IDLE: jump is committed first; bus_addr uses the new pc.
- Timeout: counter runs in OP_REQ/IMM_REQ. If BUS_TIMEOUT_CYCLES!=0 and the count reaches BUS_TIMEOUT_CYCLES without ack: bus_rd_req=0, fetch_error=1, IDLE, no memory_acknowledge, pc unchanged.
- clear (any state): IDLE next cycle; bus_rd_req=0. A bus_ack in the same cycle is discarded (no pc increment, no acknowledge). Byte counter, pending request, pending jump and fetch_error are cleared. opcode/imm_i/pc are retained. clear beats all other inputs.
- Reset mid-fetch: immediate return to reset values; a late bus_ack after reset in IDLE is ignored.

Test Plan:
- Reset, next_instr_req pulse, bus_ack after 2 wait cycles with rdata 0x3E -> bus_addr=0x0000 held; opcode=0x3E, imm_i=0, pc=0x0001, single memory_acknowledge pulse.
- Fetch C3, then two imm_byte_req with rdata 0x34, 0x12 -> imm_i=0x0034 then 0x1234; pc=0x0003; three ack pulses.
- pc=0x0010, pc_load, call_or_jump=1, cond_true=1, relative, offset 0xFE -> pc=0x000E. Same with cond_true=0 -> pc=0x0010. Absolute jump_target 0xFFFF followed by a fetch -> bus_addr=0xFFFF, pc wraps to 0x0000.
- OP_REQ with clear and bus_ack in the same cycle -> no acknowledge, pc unchanged, bus_rd_req low next cycle.
- BUS_TIMEOUT_CYCLES=4, no ack -> bus_rd_req drops after 4 cycles, fetch_error=1 until clear.
- hold=1 with next_instr_req pulse -> no bus_rd_req. Release hold -> fetch issued. pc_load during OP_REQ -> applied after ack, next fetch at the jump target.
